// File: rtl/multi_clkdiv_gen_pkg.sv
// rtl/multi_clkdiv_gen_pkg.sv - shared types and constants for the multi-channel clock divider
package multi_clkdiv_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } chan_state_e;

  localparam int MIN_PERIOD = 2;

  // Channel-select width; a single-channel build still needs a 1-bit field.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/multi_clkdiv_gen_if.sv
// rtl/multi_clkdiv_gen_if.sv - configuration write bus with accept/reject pulses
interface multi_clkdiv_gen_if
  import multi_clkdiv_gen_pkg::*;
#(
  parameter int NCH      = 4,
  parameter int PERIOD_W = 16
);

  localparam int CH_W = ch_width(NCH);

  logic                cfg_wr;
  logic [CH_W-1:0]     cfg_ch;
  logic [PERIOD_W-1:0] cfg_period;
  logic [PERIOD_W-1:0] cfg_high;
  logic                cfg_ack;
  logic                cfg_err;

  modport master (
    output cfg_wr, cfg_ch, cfg_period, cfg_high,
    input  cfg_ack, cfg_err
  );

  modport slave (
    input  cfg_wr, cfg_ch, cfg_period, cfg_high,
    output cfg_ack, cfg_err
  );

endinterface

// File: rtl/multi_clkdiv_gen_chan.sv
// rtl/multi_clkdiv_gen_chan.sv - one divider channel: counter, enable FSM, shadow/active config
module multi_clkdiv_gen_chan
  import multi_clkdiv_gen_pkg::*;
#(
  parameter int PERIOD_W   = 16,
  parameter int DEF_PERIOD = 10,
  parameter int DEF_HIGH   = 5
)(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                sync,
  input  logic                ld,
  input  logic [PERIOD_W-1:0] ld_period,
  input  logic [PERIOD_W-1:0] ld_high,
  output logic                div_clk,
  output logic                div_tick,
  output logic                pend
);

  chan_state_e         state_q, state_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [PERIOD_W-1:0] per_act_q, per_act_d, high_act_q, high_act_d;
  logic [PERIOD_W-1:0] per_sh_q, per_sh_d, high_sh_q, high_sh_d;
  logic                pend_q, pend_d;
  logic                clk_q, clk_d, tick_q, tick_d;
  logic                restart_q, restart_d;
  logic                boundary, apply;

  assign boundary = (cnt_q == per_act_q - PERIOD_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    per_act_d  = per_act_q;
    high_act_d = high_act_q;
    per_sh_d   = per_sh_q;
    high_sh_d  = high_sh_q;
    pend_d     = pend_q;
    clk_d      = 1'b0;
    tick_d     = 1'b0;
    restart_d  = 1'b0;
    apply      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        apply = pend_q;
        if (en) state_d = ST_RUN;
      end
      ST_RUN, ST_DRAIN: begin
        clk_d  = (cnt_q < high_act_q);
        // A sync restart counts as a new rising edge even if the output was already high.
        tick_d = clk_d && (!clk_q || restart_q);
        if (sync) begin
          cnt_d     = '0;
          apply     = pend_q;
          restart_d = 1'b1;
          state_d   = en ? ST_RUN : ST_DRAIN;
        end else if (boundary) begin
          cnt_d   = '0;
          apply   = pend_q;
          state_d = en ? ST_RUN : ST_IDLE;
        end else begin
          cnt_d   = cnt_q + PERIOD_W'(1);
          state_d = en ? ST_RUN : ST_DRAIN;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (apply) begin
      per_act_d  = per_sh_q;
      high_act_d = high_sh_q;
      pend_d     = 1'b0;
    end
    // A write landing on the apply edge stays in shadow for the next boundary.
    if (ld) begin
      per_sh_d  = ld_period;
      high_sh_d = ld_high;
      pend_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      per_act_q  <= PERIOD_W'(DEF_PERIOD);
      high_act_q <= PERIOD_W'(DEF_HIGH);
      per_sh_q   <= PERIOD_W'(DEF_PERIOD);
      high_sh_q  <= PERIOD_W'(DEF_HIGH);
      pend_q     <= 1'b0;
      clk_q      <= 1'b0;
      tick_q     <= 1'b0;
      restart_q  <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      per_act_q  <= per_act_d;
      high_act_q <= high_act_d;
      per_sh_q   <= per_sh_d;
      high_sh_q  <= high_sh_d;
      pend_q     <= pend_d;
      clk_q      <= clk_d;
      tick_q     <= tick_d;
      restart_q  <= restart_d;
    end
  end

  assign div_clk  = clk_q;
  assign div_tick = tick_q;
  assign pend     = pend_q;

endmodule

// File: rtl/multi_clkdiv_gen.sv
// rtl/multi_clkdiv_gen.sv - NCH programmable glitch-free clock dividers with edge ticks
module multi_clkdiv_gen
  import multi_clkdiv_gen_pkg::*;
#(
  parameter int NCH        = 4,
  parameter int PERIOD_W   = 16,
  parameter int DEF_PERIOD = 10,
  parameter int DEF_HIGH   = 5
)(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NCH-1:0]        ch_en,
  input  logic                  sync,
  multi_clkdiv_gen_if.slave     cfg,
  output logic [NCH-1:0]        div_clk,
  output logic [NCH-1:0]        div_tick,
  output logic [NCH-1:0]        cfg_pend
);

  localparam int CH_W = ch_width(NCH);

  logic           ch_ok, period_ok, wr_ok;
  logic           ack_q, err_q;
  logic [NCH-1:0] ld;

  // Extra bit so NCH itself is representable when NCH is a power of two.
  assign ch_ok     = ({1'b0, cfg.cfg_ch} < (CH_W + 1)'(NCH));
  assign period_ok = (cfg.cfg_period >= PERIOD_W'(MIN_PERIOD));
  assign wr_ok     = cfg.cfg_wr && ch_ok && period_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      ack_q <= wr_ok;
      err_q <= cfg.cfg_wr && !wr_ok;
    end
  end

  assign cfg.cfg_ack = ack_q;
  assign cfg.cfg_err = err_q;

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    assign ld[i] = wr_ok && (cfg.cfg_ch == CH_W'(i));

    multi_clkdiv_gen_chan #(
      .PERIOD_W   (PERIOD_W),
      .DEF_PERIOD (DEF_PERIOD),
      .DEF_HIGH   (DEF_HIGH)
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (ch_en[i]),
      .sync      (sync),
      .ld        (ld[i]),
      .ld_period (cfg.cfg_period),
      .ld_high   (cfg.cfg_high),
      .div_clk   (div_clk[i]),
      .div_tick  (div_tick[i]),
      .pend      (cfg_pend[i])
    );
  end

endmodule

// File: tb/tb_multi_clkdiv_gen.sv
// tb/tb_multi_clkdiv_gen.sv - directed self-checking bench for multi_clkdiv_gen
module tb_multi_clkdiv_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] ch_en = 4'b0000;
  logic       sync = 1'b0;
  logic [3:0] div_clk, div_tick, cfg_pend;

  logic [63:0] seq0, seq1, tk0, tk1;
  logic        others;
  int          n_cmp = 0;
  int          n_fail = 0;

  multi_clkdiv_gen_if #(.NCH(4), .PERIOD_W(16)) cfg_bus ();

  multi_clkdiv_gen #(
    .NCH(4), .PERIOD_W(16), .DEF_PERIOD(10), .DEF_HIGH(5)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ch_en    (ch_en),
    .sync     (sync),
    .cfg      (cfg_bus),
    .div_clk  (div_clk),
    .div_tick (div_tick),
    .cfg_pend (cfg_pend)
  );

  always #5 clk = ~clk;

  task automatic clear_seq();
    seq0 = '0; seq1 = '0; tk0 = '0; tk1 = '0; others = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      seq0   = {seq0[62:0], div_clk[0]};
      seq1   = {seq1[62:0], div_clk[1]};
      tk0    = {tk0[62:0], div_tick[0]};
      tk1    = {tk1[62:0], div_tick[1]};
      others = others | (|div_clk[3:1]);
    end
  endtask

  task automatic set_cfg(input logic wr, input logic [1:0] ch, input logic [15:0] per, input logic [15:0] hi);
    cfg_bus.cfg_wr     = wr;
    cfg_bus.cfg_ch     = ch;
    cfg_bus.cfg_period = per;
    cfg_bus.cfg_high   = hi;
  endtask

  task automatic test_reset();
    set_cfg(1'b0, 2'd0, 16'd0, 16'd0);
    run(3);
    n_cmp++; if (div_clk !== 4'b0) begin n_fail++; $display("FAIL reset_div_clk: got %b want 0000", div_clk); end
    n_cmp++; if (div_tick !== 4'b0) begin n_fail++; $display("FAIL reset_div_tick: got %b want 0000", div_tick); end
    n_cmp++; if (cfg_pend !== 4'b0) begin n_fail++; $display("FAIL reset_cfg_pend: got %b want 0000", cfg_pend); end
    n_cmp++; if ({cfg_bus.cfg_ack, cfg_bus.cfg_err} !== 2'b00) begin n_fail++; $display("FAIL reset_ack_err: got %b want 00", {cfg_bus.cfg_ack, cfg_bus.cfg_err}); end
  endtask

  task automatic test_default_run();
    ch_en = 4'b0001;
    rst_n = 1'b1;
    clear_seq();
    run(21);
    n_cmp++; if (seq0 !== 64'h0F83E0) begin n_fail++; $display("FAIL default_wave: got %h want 0f83e0", seq0); end
    n_cmp++; if (tk0 !== 64'h080200) begin n_fail++; $display("FAIL default_tick: got %h want 080200", tk0); end
    n_cmp++; if (others !== 1'b0) begin n_fail++; $display("FAIL idle_channels: got %b want 0", others); end
  endtask

  task automatic test_cfg_write();
    run(3);
    set_cfg(1'b1, 2'd0, 16'd4, 16'd1);
    run(1);
    set_cfg(1'b0, 2'd0, 16'd0, 16'd0);
    n_cmp++; if (cfg_bus.cfg_ack !== 1'b1) begin n_fail++; $display("FAIL wr_ack: got %b want 1", cfg_bus.cfg_ack); end
    n_cmp++; if (cfg_pend[0] !== 1'b1) begin n_fail++; $display("FAIL wr_pend: got %b want 1", cfg_pend[0]); end
    clear_seq();
    run(1);
    n_cmp++; if (cfg_bus.cfg_ack !== 1'b0) begin n_fail++; $display("FAIL wr_ack_pulse: got %b want 0", cfg_bus.cfg_ack); end
    run(13);
    n_cmp++; if (seq0 !== 64'h2088) begin n_fail++; $display("FAIL wr_wave: got %h want 2088", seq0); end
    n_cmp++; if (tk0 !== 64'h0088) begin n_fail++; $display("FAIL wr_tick: got %h want 0088", tk0); end
    n_cmp++; if (cfg_pend[0] !== 1'b0) begin n_fail++; $display("FAIL wr_pend_clear: got %b want 0", cfg_pend[0]); end
  endtask

  task automatic test_cfg_edges();
    set_cfg(1'b1, 2'd0, 16'd1, 16'd1);
    clear_seq();
    run(1);
    set_cfg(1'b0, 2'd0, 16'd0, 16'd0);
    n_cmp++; if ({cfg_bus.cfg_err, cfg_bus.cfg_ack} !== 2'b10) begin n_fail++; $display("FAIL bad_period_err_ack: got %b want 10", {cfg_bus.cfg_err, cfg_bus.cfg_ack}); end
    run(1);
    n_cmp++; if (cfg_bus.cfg_err !== 1'b0) begin n_fail++; $display("FAIL err_pulse: got %b want 0", cfg_bus.cfg_err); end
    run(6);
    n_cmp++; if (seq0 !== 64'h88) begin n_fail++; $display("FAIL bad_period_wave: got %h want 88", seq0); end
    n_cmp++; if (cfg_pend[0] !== 1'b0) begin n_fail++; $display("FAIL bad_period_pend: got %b want 0", cfg_pend[0]); end

    set_cfg(1'b1, 2'd0, 16'd4, 16'd0);
    clear_seq();
    run(1);
    set_cfg(1'b0, 2'd0, 16'd0, 16'd0);
    n_cmp++; if (cfg_bus.cfg_ack !== 1'b1) begin n_fail++; $display("FAIL high0_ack: got %b want 1", cfg_bus.cfg_ack); end
    run(11);
    n_cmp++; if (seq0 !== 64'h800) begin n_fail++; $display("FAIL high0_wave: got %h want 800", seq0); end
    n_cmp++; if (tk0 !== 64'h800) begin n_fail++; $display("FAIL high0_tick: got %h want 800", tk0); end

    set_cfg(1'b1, 2'd0, 16'd10, 16'd12);
    clear_seq();
    run(1);
    set_cfg(1'b0, 2'd0, 16'd0, 16'd0);
    run(23);
    n_cmp++; if (seq0 !== 64'h0FFFFF) begin n_fail++; $display("FAIL high_ge_per_wave: got %h want 0fffff", seq0); end
    n_cmp++; if (tk0 !== 64'h080000) begin n_fail++; $display("FAIL high_ge_per_tick: got %h want 080000", tk0); end
  endtask

  task automatic test_enable();
    set_cfg(1'b1, 2'd0, 16'd10, 16'd5);
    run(1);
    set_cfg(1'b0, 2'd0, 16'd0, 16'd0);
    run(9);
    n_cmp++; if (cfg_pend[0] !== 1'b0) begin n_fail++; $display("FAIL restore_pend: got %b want 0", cfg_pend[0]); end
    clear_seq();
    run(2);
    ch_en = 4'b0000;
    run(14);
    n_cmp++; if (seq0 !== 64'hF800) begin n_fail++; $display("FAIL drain_wave: got %h want f800", seq0); end
    ch_en = 4'b0001;
    clear_seq();
    run(3);
    ch_en = 4'b0000;
    run(5);
    ch_en = 4'b0001;
    run(8);
    n_cmp++; if (seq0 !== 64'h7C1F) begin n_fail++; $display("FAIL reenable_wave: got %h want 7c1f", seq0); end
    n_cmp++; if (tk0 !== 64'h4010) begin n_fail++; $display("FAIL reenable_tick: got %h want 4010", tk0); end
  endtask

  task automatic test_sync();
    set_cfg(1'b1, 2'd1, 16'd9, 16'd4);
    run(1);
    set_cfg(1'b0, 2'd0, 16'd0, 16'd0);
    n_cmp++; if (cfg_pend[1] !== 1'b1) begin n_fail++; $display("FAIL idle_pend_set: got %b want 1", cfg_pend[1]); end
    run(1);
    n_cmp++; if (cfg_pend[1] !== 1'b0) begin n_fail++; $display("FAIL idle_apply: got %b want 0", cfg_pend[1]); end
    ch_en = 4'b0011;
    run(7);
    set_cfg(1'b1, 2'd0, 16'd6, 16'd3);
    run(1);
    set_cfg(1'b0, 2'd0, 16'd0, 16'd0);
    sync = 1'b1;
    run(1);
    sync = 1'b0;
    n_cmp++; if (cfg_pend[1:0] !== 2'b00) begin n_fail++; $display("FAIL sync_apply_pend: got %b want 00", cfg_pend[1:0]); end
    clear_seq();
    run(12);
    n_cmp++; if (seq0 !== 64'hE38) begin n_fail++; $display("FAIL sync_ch0_wave: got %h want e38", seq0); end
    n_cmp++; if (tk0 !== 64'h820) begin n_fail++; $display("FAIL sync_ch0_tick: got %h want 820", tk0); end
    n_cmp++; if (seq1 !== 64'hF07) begin n_fail++; $display("FAIL sync_ch1_wave: got %h want f07", seq1); end
    n_cmp++; if (tk1 !== 64'h804) begin n_fail++; $display("FAIL sync_ch1_tick: got %h want 804", tk1); end
  endtask

  task automatic test_sync_with_write();
    set_cfg(1'b1, 2'd0, 16'd4, 16'd1);
    sync = 1'b1;
    run(1);
    set_cfg(1'b0, 2'd0, 16'd0, 16'd0);
    sync = 1'b0;
    n_cmp++; if ({cfg_bus.cfg_ack, cfg_pend[0]} !== 2'b11) begin n_fail++; $display("FAIL sync_wr_deferred: got %b want 11", {cfg_bus.cfg_ack, cfg_pend[0]}); end
    clear_seq();
    run(10);
    n_cmp++; if (seq0 !== 64'h388) begin n_fail++; $display("FAIL sync_wr_wave: got %h want 388", seq0); end
    n_cmp++; if (cfg_pend[0] !== 1'b0) begin n_fail++; $display("FAIL sync_wr_pend: got %b want 0", cfg_pend[0]); end
  endtask

  task automatic test_back_to_back();
    clear_seq();
    set_cfg(1'b1, 2'd0, 16'd8, 16'd2);
    run(1);
    set_cfg(1'b1, 2'd0, 16'd5, 16'd2);
    run(1);
    set_cfg(1'b0, 2'd0, 16'd0, 16'd0);
    run(8);
    n_cmp++; if (seq0 !== 64'h231) begin n_fail++; $display("FAIL last_write_wins: got %h want 231", seq0); end
  endtask

  task automatic test_reset_midperiod();
    set_cfg(1'b1, 2'd0, 16'd7, 16'd3);
    run(1);
    set_cfg(1'b0, 2'd0, 16'd0, 16'd0);
    n_cmp++; if ({div_clk[0], cfg_pend[0]} !== 2'b11) begin n_fail++; $display("FAIL pre_reset_state: got %b want 11", {div_clk[0], cfg_pend[0]}); end
    rst_n = 1'b0;
    #2;
    n_cmp++; if ({div_clk, div_tick, cfg_pend} !== 12'h000) begin n_fail++; $display("FAIL async_reset_outputs: got %h want 000", {div_clk, div_tick, cfg_pend}); end
    n_cmp++; if ({cfg_bus.cfg_ack, cfg_bus.cfg_err} !== 2'b00) begin n_fail++; $display("FAIL async_reset_ack_err: got %b want 00", {cfg_bus.cfg_ack, cfg_bus.cfg_err}); end
    run(2);
    ch_en = 4'b0001;
    rst_n = 1'b1;
    clear_seq();
    run(21);
    n_cmp++; if (seq0 !== 64'h0F83E0) begin n_fail++; $display("FAIL post_reset_wave: got %h want 0f83e0", seq0); end
    n_cmp++; if (tk0 !== 64'h080200) begin n_fail++; $display("FAIL post_reset_tick: got %h want 080200", tk0); end
    n_cmp++; if (cfg_pend !== 4'b0) begin n_fail++; $display("FAIL post_reset_pend: got %b want 0000", cfg_pend); end
  endtask

  initial begin
    test_reset();
    test_default_run();
    test_cfg_write();
    test_cfg_edges();
    test_enable();
    test_sync();
    test_sync_with_write();
    test_back_to_back();
    test_reset_midperiod();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
